// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI mode-0 slave, MSB first, fully oversampled in the clk domain.
// Receives words into dout and returns host-loaded words on miso.
module spi_slave_duplex #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_empty,
    output logic             tx_underrun,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_sclk_sync;
    logic [2:0]       r_cs_sync;
    logic [2:0]       r_mosi_sync;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_tx_buf;
    logic             r_pending;
    logic             r_skip_fall;

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi_s;
    logic w_start, w_end, w_rise, w_fall, w_word_done, w_reload;

    // Bit 1 of each chain is the synchronized level, bit 2 its one-cycle delay.
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_mosi_s    = r_mosi_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A cs rise takes priority over any sclk edge seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_end        = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = SHIFT;
                    w_start      = 1'b1;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_end        = 1'b1;
                end else if (w_sclk_rise) begin
                    w_rise = 1'b1;
                end else if (w_sclk_fall) begin
                    w_fall = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_word_done = w_rise && (r_bit_cnt == LAST_BIT);
    assign w_reload    = w_start | w_word_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_tx_buf    <= '0;
            r_pending   <= 1'b0;
            r_skip_fall <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_cs_sync   <= {r_cs_sync[1:0], cs};
            r_mosi_sync <= {r_mosi_sync[1:0], mosi};
            dout_valid  <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            if (tx_load) begin
                r_tx_buf <= tx_data;
            end
            // A load coinciding with a reload bypasses straight into the shifter.
            if (w_reload) begin
                r_pending <= 1'b0;
                if (tx_load) begin
                    r_tx_shift <= tx_data;
                end else if (r_pending) begin
                    r_tx_shift <= r_tx_buf;
                end else begin
                    r_tx_shift  <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (tx_load) begin
                r_pending <= 1'b1;
            end

            if (w_start) begin
                r_bit_cnt   <= '0;
                r_skip_fall <= 1'b0;
            end

            if (w_end) begin
                frame_err <= (r_bit_cnt != '0);
                r_bit_cnt <= '0;
            end

            if (w_rise) begin
                r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi_s};
                if (w_word_done) begin
                    dout        <= {r_rx_shift[WIDTH-2:0], w_mosi_s};
                    dout_valid  <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_skip_fall <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            // The fall right after a word-boundary reload keeps the new MSB on miso.
            if (w_fall) begin
                if (r_skip_fall) begin
                    r_skip_fall <= 1'b0;
                end else begin
                    r_tx_shift <= r_tx_shift << 1;
                end
            end
        end
    end

    assign miso_oe  = (r_state == SHIFT);
    assign miso     = miso_oe & r_tx_shift[WIDTH-1];
    assign tx_empty = ~r_pending;

endmodule

// File: tb/tb_spi_slave_duplex.sv
// Bench for spi_slave_duplex: bit-banged SPI master, tx-buffer reference model,
// and a scoreboard monitor that checks every dout_valid against queued words.
module tb_spi_slave_duplex;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         cs;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [W-1:0] tx_data;
    logic         tx_load;
    logic         tx_empty;
    logic         tx_underrun;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         frame_err;

    spi_slave_duplex #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_empty(tx_empty), .tx_underrun(tx_underrun), .dout(dout),
        .dout_valid(dout_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fails = 0;
    logic [W-1:0] exp_q[$];
    int           n_ferr = 0, n_unf = 0;
    int           m_ferr = 0, m_unf = 0;
    bit           m_pending = 0;
    logic [W-1:0] m_buf = '0;
    logic [W-1:0] m_cur_tx = '0;
    logic [W-1:0] m_last_dout = '0;
    logic         prev_valid = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fails++;
                $display("FAIL dout_valid_unexpected: got pulse with dout %h expected none", dout);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
            check1("dout_valid_width", prev_valid, 1'b0);
        end
        if (frame_err) n_ferr++;
        if (tx_underrun) n_unf++;
        prev_valid = dout_valid;
    end

    // Reference model: the word sent next is the buffered one, or zero with an underrun.
    task automatic model_take(output logic [W-1:0] w);
        if (m_pending) begin
            m_pending = 0;
            w = m_buf;
        end else begin
            m_unf++;
            w = '0;
        end
    endtask

    task automatic host_load(input logic [W-1:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        m_buf = d;
        m_pending = 1;
    endtask

    task automatic start_frame();
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        model_take(m_cur_tx);
        check_int("underrun_at_start", n_unf, m_unf);
        check1("tx_empty_at_start", tx_empty, !m_pending);
        check1("miso_oe_in_frame", miso_oe, 1'b1);
    endtask

    task automatic xfer_word(input logic [W-1:0] mw, input int nbits, input bit collide,
                             input logic [W-1:0] cdata, input bit live);
        logic [W-1:0] got;
        got = '0;
        if (live && nbits == W) begin
            exp_q.push_back(mw);
            m_last_dout = mw;
        end
        for (int i = 0; i < nbits; i++) begin
            mosi = mw[W-1-i];
            repeat (4) @(negedge clk);
            got = {got[W-2:0], miso};
            sclk = 1'b1;
            if (i == W-1 && collide) begin
                repeat (2) @(negedge clk);
                tx_data = cdata;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            sclk = 1'b0;
        end
        if (live && nbits == W) begin
            check("miso_word", got, m_cur_tx);
            if (collide) begin
                m_cur_tx = cdata;
                m_pending = 0;
            end else begin
                model_take(m_cur_tx);
            end
            check_int("underrun_count", n_unf, m_unf);
            check1("tx_empty_after_word", tx_empty, !m_pending);
        end
    endtask

    task automatic end_frame(input bit partial);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        if (partial) m_ferr++;
        check_int("frame_err_count", n_ferr, m_ferr);
        check1("miso_oe_idle", miso_oe, 1'b0);
        check1("miso_idle", miso, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_miso"}, miso, 1'b0);
        check1({tag, "_miso_oe"}, miso_oe, 1'b0);
        check({tag, "_dout"}, dout, '0);
        check1({tag, "_dout_valid"}, dout_valid, 1'b0);
        check1({tag, "_frame_err"}, frame_err, 1'b0);
        check1({tag, "_tx_underrun"}, tx_underrun, 1'b0);
        check1({tag, "_tx_empty"}, tx_empty, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single word
        host_load(32'hA5A5_0F0F);
        start_frame();
        xfer_word(32'hDEAD_BEEF, W, 1'b0, '0, 1'b1);
        end_frame(1'b0);

        // Back-to-back words with a load during the first
        host_load(32'h0BAD_F00D);
        start_frame();
        host_load(32'h1111_1111);
        xfer_word(32'h1234_5678, W, 1'b0, '0, 1'b1);
        xfer_word(32'h9ABC_DEF0, W, 1'b0, '0, 1'b1);
        end_frame(1'b0);

        // Underrun at frame start
        start_frame();
        xfer_word($urandom, W, 1'b0, '0, 1'b1);
        end_frame(1'b0);

        // Aborted frame, then a good one
        host_load($urandom);
        start_frame();
        xfer_word($urandom, 13, 1'b0, '0, 1'b1);
        end_frame(1'b1);
        check("dout_kept_after_abort", dout, m_last_dout);
        start_frame();
        xfer_word(32'h0000_0001, W, 1'b0, '0, 1'b1);
        end_frame(1'b0);

        // Reset mid-frame
        host_load($urandom);
        start_frame();
        xfer_word($urandom, 20, 1'b0, '0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        m_pending = 0;
        m_last_dout = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        xfer_word($urandom, W, 1'b0, '0, 1'b0);
        check1("no_oe_after_reset", miso_oe, 1'b0);
        check("dout_after_reset", dout, '0);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        start_frame();
        xfer_word(32'hCAFE_F00D, W, 1'b0, '0, 1'b1);
        end_frame(1'b0);
        check("dout_cafef00d", dout, 32'hCAFE_F00D);

        // Load collision at the word boundary
        host_load($urandom);
        start_frame();
        xfer_word($urandom, W, 1'b1, 32'h5555_AAAA, 1'b1);
        xfer_word($urandom, W, 1'b0, '0, 1'b1);
        end_frame(1'b0);

        // Randomized frames
        repeat (6) begin
            int nw;
            if ($urandom_range(1, 0) == 1) host_load($urandom);
            start_frame();
            nw = $urandom_range(3, 1);
            for (int k = 0; k < nw; k++) begin
                bit col;
                if ($urandom_range(1, 0) == 1) host_load($urandom);
                col = (k < nw - 1) && ($urandom_range(3, 0) == 0);
                xfer_word($urandom, W, col, $urandom, 1'b1);
            end
            end_frame(1'b0);
        end

        repeat (10) @(negedge clk);
        check_int("scoreboard_empty", exp_q.size(), 0);
        check_int("final_underruns", n_unf, m_unf);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_duplex.md
# spi_slave_duplex

Full-duplex SPI slave (mode 0, MSB first) that runs entirely in the system `clk` domain. It oversamples the `sclk`/`cs`/`mosi` pins, shifts received words into `dout`, and drives `miso` from a host-loaded transmit word. It is the responding end of the link driven by `spi_master`, and it adds a return path that the receive-only slave lacks.

## Interface
- `WIDTH`, 32, word length in bits (≥2).
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sclk` in 1: SPI clock from the master; asynchronous to `clk`.
- `cs` in 1: chip select, active low; asynchronous.
- `mosi` in 1: master-out data; asynchronous.
- `miso` out 1: slave-out data.
- `miso_oe` out 1: output enable for the `miso` pad.
- `tx_data` in WIDTH: next word to transmit.
- `tx_load` in 1: one-cycle strobe that captures `tx_data`.
- `tx_empty` out 1: high when no unsent word is buffered.
- `tx_underrun` out 1: one-cycle pulse when a word starts with no buffered word.
- `dout` out WIDTH: last complete received word.
- `dout_valid` out 1: one-cycle pulse when `dout` updates.
- `frame_err` out 1: one-cycle pulse when `cs` deasserts mid-word.

## Operation
- **Synchronizers.** `sclk`, `cs` and `mosi` each pass through 2 flops, plus a third delay flop for edge detection.
  - Rising edge: `s2 & ~s3`. Falling edge: `~s2 & s3`.
  - The `cs` chain resets to 0. A frame therefore needs `cs` seen high, then low, after reset.
  - The `sclk` and `mosi` chains reset to 0.
- **States:** IDLE, SHIFT.
  - IDLE → SHIFT on a `cs` falling edge. On this transition: `bit_cnt`=0, `tx_shift` loaded (rule below), `miso_oe`=1.
  - SHIFT, `sclk` rise:
    - `rx_shift` ← {`rx_shift[WIDTH-2:0]`, `mosi_s`}.
    - `bit_cnt`++.
    - If `bit_cnt`==WIDTH-1: `dout` ← {`rx_shift[WIDTH-2:0]`, `mosi_s`}, `dout_valid`=1, `bit_cnt`=0, and `tx_shift` reloads for the next word. The slave stays in SHIFT, so multiple words per `cs` are allowed.
  - SHIFT, `sclk` fall:
    - `tx_shift` ← `tx_shift << 1`.
    - Suppressed when a reload occurred on the preceding rise of the same bit period. The reloaded MSB must stay on `miso` for bit 0.
  - SHIFT → IDLE on a `cs` rising edge.
    - If `bit_cnt`≠0: pulse `frame_err` and discard the partial word. `dout` is unchanged.
    - If `bit_cnt`==0: no error.
    - `miso_oe`=0 in both cases.
- **`miso`.** Equals `tx_shift[WIDTH-1]` when `miso_oe`=1, otherwise 0. `miso_oe`=1 exactly when state is SHIFT.
- **Tx buffer.** `tx_load` writes `tx_buf` and sets `pending`; `tx_empty`=~`pending`.
  - Load rule at frame start or word boundary:
    - `pending`=1: `tx_shift` ← `tx_buf`, `pending` cleared.
    - `pending`=0: `tx_shift` ← 0 and `tx_underrun` pulses.
  - `tx_load` in the same cycle as a load: `tx_data` bypasses into `tx_shift`, `pending` stays 0, no underrun.
  - `tx_load` while `pending`=1 with no load: the buffer is overwritten and the older word is lost.
- **Simultaneous events.**
  - `cs` rise in the same cycle as a `sclk` rise: the `cs` rise wins and the `sclk` edge is ignored.
  - `cs` fall in SHIFT: impossible, since `cs` is already low.

## Timing
- `sclk` high and low phases must each be ≥4 `clk` periods. `cs` setup to the first `sclk` rise must be ≥4 `clk` periods.
- Pin-to-edge-detect latency: 2 `clk` edges. The action registers on the 3rd `clk` edge after the pin change.
- `dout_valid` and `dout` update on the 3rd `clk` edge after the last `sclk` rise at the pin. The pulse is exactly 1 cycle.
- `miso` changes 3 `clk` edges after a `sclk` fall, which meets the next rise at the master under the ratio above.
- Bit 0 appears on `miso` 3 `clk` edges after `cs` falls.
- Reset values:
  - `miso`=0, `miso_oe`=0, `dout`=0.
  - `dout_valid`, `frame_err`, `tx_underrun` = 0.
  - `tx_empty`=1, `tx_buf`=0, state IDLE, `bit_cnt`=0.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The bench must see no `dout_valid` for the interrupted word.

## Test plan
- **Single word.** `tx_load` 0xA5A5_0F0F, then the master sends 0xDEAD_BEEF at `clk`/8 → `dout`=0xDEAD_BEEF, `dout_valid` one 1-cycle pulse, `miso` bitstream = 0xA5A5_0F0F, `tx_empty`=1 after the frame starts.
- **Back-to-back words.** Two words under one `cs`: 0x1234_5678 then 0x9ABC_DEF0, with a `tx_load` of 0x1111_1111 between them → two `dout_valid` pulses with those values, second `miso` word = 0x1111_1111, no `frame_err`.
- **Underrun.** No `tx_load` before the frame → `tx_underrun` pulses once at `cs` fall, `miso` = all zeros, `dout` still correct.
- **Aborted frame.** `cs` raised after 13 bits → `frame_err` pulses once, `dout` keeps its prior value, no `dout_valid`. The next full frame of 0x0000_0001 is received correctly.
- **Reset mid-frame.** Assert `rst` after 20 bits with `cs` low → all outputs at reset values. Release `rst` with `cs` still low → no activity until `cs` goes high then low, after which a full word 0xCAFE_F00D is received correctly.
- **Load collision.** `tx_load` 0x5555_AAAA in the same cycle as the word-boundary load → 0x5555_AAAA is transmitted, `tx_empty`=1, no `tx_underrun`.
